// File: rtl/onchip_mem_loader.sv
// Streams bytes from a valid/ready sink into a 32-bit on-chip memory, packing little-endian.
// Define ONCHIP_LOADER_CHECKSUM_EN to include the 16-bit byte-sum accumulator.
module onchip_mem_loader #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [7:0]        sink_data,
  input  logic              sink_valid,
  output logic              sink_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum
);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remain_q;
  logic [1:0]        lane_q;
  logic [23:0]       word_q;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] waddr_q;

  logic        accept;
  logic        last_byte;
  logic        flush_word;
  logic        start_load;
  logic [31:0] packed_word;
  logic [3:0]  fill_be;

  assign sink_ready = (state_q == StLoad);
  assign accept     = sink_ready & sink_valid;
  assign last_byte  = (remain_q == LEN_W'(1));
  assign flush_word = (lane_q == 2'd3) | last_byte;
  assign start_load = ((state_q == StIdle) || (state_q == StDone)) && start && (length != '0);

  // Lanes above the current one are always zero because word_q is cleared on every write.
  always_comb begin
    packed_word = {8'h00, word_q};
    packed_word[{lane_q, 3'b000} +: 8] = sink_data;
    unique case (lane_q)
      2'd0:    fill_be = 4'b0001;
      2'd1:    fill_be = 4'b0011;
      2'd2:    fill_be = 4'b0111;
      default: fill_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      remain_q <= '0;
      lane_q   <= '0;
      word_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      waddr_q  <= '0;
    end else begin
      wr_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      waddr_q <= '0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start_load) begin
            state_q  <= StLoad;
            addr_q   <= base_addr;
            remain_q <= length;
            lane_q   <= '0;
            word_q   <= '0;
          end else if (start) begin
            state_q <= StDone;
          end
        end
        StLoad: begin
          if (accept) begin
            remain_q <= remain_q - LEN_W'(1);
            if (flush_word) begin
              wr_q    <= 1'b1;
              wdata_q <= packed_word;
              be_q    <= fill_be;
              waddr_q <= addr_q;
              addr_q  <= addr_q + ADDR_W'(1);
              lane_q  <= '0;
              word_q  <= '0;
            end else begin
              lane_q <= lane_q + 2'd1;
              word_q <= packed_word[23:0];
            end
            if (last_byte) state_q <= StFlush;
          end
        end
        StFlush: state_q <= StDone;
      endcase
    end
  end

  assign mem_write      = wr_q;
  assign mem_chipselect = wr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;
  assign mem_address    = waddr_q;
  assign mem_clken      = 1'b1;
  assign busy           = (state_q == StLoad) || (state_q == StFlush);
  assign done           = (state_q == StDone);

`ifdef ONCHIP_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if (start_load) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + {8'h00, sink_data};
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_onchip_mem_loader.sv
// Randomized bench for onchip_mem_loader; expected writes are built from the byte list by chunking.
module tb_onchip_mem_loader;
  localparam int ADDR_W = 13;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic [7:0]        sink_data;
  logic              sink_valid;
  logic              sink_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic              busy;
  logic              done;
  logic [15:0]       checksum;

  onchip_mem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .sink_data      (sink_data),
    .sink_valid     (sink_valid),
    .sink_ready     (sink_ready),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .busy           (busy),
    .done           (done),
    .checksum       (checksum)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  pay_q[$];
  logic [48:0] obs_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: records every write and checks per-cycle bus invariants.
  always @(negedge clk) begin
    check_eq("cs_eq_write", {63'd0, mem_chipselect}, {63'd0, mem_write});
    check_eq("clken", {63'd0, mem_clken}, 64'd1);
    if (mem_write === 1'b1) obs_q.push_back({mem_address, mem_byteenable, mem_writedata});
  end

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_zero"}, {sink_ready, mem_write, mem_chipselect, mem_byteenable,
                              mem_writedata, mem_address, busy, done, checksum}, 64'd0);
  endtask

  task automatic compare_writes(input logic [ADDR_W-1:0] base, input int nwr);
    logic [48:0] exp_q[$];
    for (int w = 0; w < nwr; w++) begin
      logic [31:0]       d  = '0;
      logic [3:0]        be = '0;
      logic [ADDR_W-1:0] a  = base + ADDR_W'(w);
      for (int l = 0; l < 4; l++) begin
        if (4 * w + l < pay_q.size()) begin
          d[8*l +: 8] = pay_q[4*w+l];
          be[l] = 1'b1;
        end
      end
      exp_q.push_back({a, be, d});
    end
    check_eq("write_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq($sformatf("write%0d", i), obs_q[i], exp_q[i]);
  endtask

  // mode 0: valid held high, 1: valid toggles 1/0, 2: random valid.
  task automatic run_load(input logic [ADDR_W-1:0] base, input int mode, input int rst_after,
                          input bit extra_start);
    int len = pay_q.size();
    int idx = 0;
    int cyc = 0;
    int sum = 0;
    bit tog = 1'b1;
    bit v;
    foreach (pay_q[i]) sum += pay_q[i];
    @(negedge clk);
    obs_q.delete();
    start = 1'b1; base_addr = base; length = LEN_W'(len);
    @(negedge clk);
    start = 1'b0; base_addr = $urandom;
    if (len == 0) begin
      check_eq("zl_done", {63'd0, done}, 64'd1);
      check_eq("zl_busy", {63'd0, busy}, 64'd0);
      repeat (3) @(negedge clk);
      check_eq("zl_busy_later", {62'd0, busy, done}, 64'd1);
      check_eq("zl_writes", obs_q.size(), 0);
      return;
    end
    check_eq("load_busy", {62'd0, busy, done}, 64'd2);
`ifdef ONCHIP_LOADER_CHECKSUM_EN
    check_eq("sum_clear", checksum, 64'd0);
`endif
    while (idx < len && cyc < 20 * len + 20) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 9) < 7);
      sink_valid = v;
      sink_data  = pay_q[idx];
      if (extra_start && cyc == 2) begin
        start = 1'b1; base_addr = base + ADDR_W'(100); length = LEN_W'(3);
      end
      check_eq("ready_in_load", {63'd0, sink_ready}, 64'd1);
      @(posedge clk);
      if (v) idx++;
      tog = ~tog;
      cyc++;
      @(negedge clk);
      sink_valid = 1'b0; start = 1'b0;
      if (rst_after >= 0 && idx == rst_after) break;
    end
    if (rst_after >= 0 && idx == rst_after) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_idle_outputs("after_abort");
      repeat (6) @(negedge clk);
      check_eq("abort_no_write_later", {63'd0, mem_write}, 64'd0);
      compare_writes(base, rst_after / 4);
      return;
    end
    if (idx < len) begin
      check_eq("timeout", idx, len);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    check_eq("flush_state", {60'd0, busy, done, sink_ready, mem_write}, 64'b1001);
    @(negedge clk);
    check_eq("done_state", {61'd0, busy, done, mem_write}, 64'b010);
`ifdef ONCHIP_LOADER_CHECKSUM_EN
    check_eq("checksum", checksum, 64'(sum[15:0]));
`else
    check_eq("checksum", checksum, 64'd0);
`endif
    repeat (2) @(negedge clk);
    check_eq("done_held", {63'd0, done}, 64'd1);
    compare_writes(base, (len + 3) / 4);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    sink_data = '0; sink_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    start = 1'b1; length = 16'd4;
    @(negedge clk);
    check_idle_outputs("reset_over_start");
    reset = 1'b0; start = 1'b0;

    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(13'h0010, 0, -1, 1'b0);
    pay_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_load(13'h0100, 0, -1, 1'b0);
    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(13'h1FFF, 1, -1, 1'b0);
    pay_q.delete();
    run_load(13'h0042, 0, -1, 1'b0);
    pay_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    run_load(13'h0200, 0, 5, 1'b0);
    run_load(13'h0300, 0, -1, 1'b0);
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    run_load(13'h0400, 0, -1, 1'b1);

    for (int t = 0; t < 30; t++) begin
      int n = $urandom_range(0, 20);
      pay_q.delete();
      for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
      run_load(ADDR_W'($urandom), $urandom_range(0, 2), -1, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/onchip_mem_loader.md
ONCHIP_MEM_LOADER -- requirements
Module: onchip_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, word-address width of the downstream 32-bit on-chip memory (8192 words).
REQ-002 SHALL have parameter LEN_W, default 16, width of the byte-length input.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse that begins a load.
REQ-006 base_addr  input  ADDR_W  first word address, sampled on an accepted start.
REQ-007 length  input  LEN_W  number of bytes to load, sampled on an accepted start.
REQ-008 sink_data  input  8  stream byte.
REQ-009 sink_valid  input  1  sink_data is valid.
REQ-010 sink_ready  output  1  block accepts a byte this cycle; a transfer occurs when valid and ready are both high.
REQ-011 mem_address  output  ADDR_W  word address to the memory.
REQ-012 mem_byteenable  output  4  byte lanes to write.
REQ-013 mem_chipselect  output  1  memory select.
REQ-014 mem_write  output  1  write strobe.
REQ-015 mem_writedata  output  32  packed write word.
REQ-016 mem_clken  output  1  memory clock enable.
REQ-017 busy  output  1  a load is in progress.
REQ-018 done  output  1  the last load completed; held until the next accepted start or reset.
REQ-019 checksum  output  16  modulo-2^16 sum of the loaded bytes.

Function
REQ-020 SHALL implement states IDLE, LOAD, FLUSH and DONE.
REQ-021 In IDLE or DONE, start with length!=0 SHALL latch base_addr and length, clear checksum and the lane counter, clear done, and enter LOAD on the next cycle.
REQ-022 In IDLE or DONE, start with length==0 SHALL enter DONE with done=1 on the next cycle and issue no write.
REQ-023 start received in LOAD or FLUSH SHALL be ignored.
REQ-024 sink_ready SHALL be 1 only in LOAD; the memory has no wait state, so the block never stalls a byte.
REQ-025 Bytes SHALL be packed little-endian: the first byte of each word goes to [7:0], the fourth to [31:24].
REQ-026 Each accepted byte in cycle t SHALL update the lane counter and the byte remaining count in cycle t+1.
REQ-027 When an accepted byte fills lane 3, or is the last byte of length, the block SHALL drive exactly one cycle in cycle t+1 with mem_write=1, mem_chipselect=1, the current word address, and the packed word.
REQ-028 On a full word, mem_byteenable SHALL be 4'b1111; on a final partial word it SHALL enable only the filled lanes (1 byte=0001, 2=0011, 3=0111); unfilled data lanes SHALL be 0.
REQ-029 mem_chipselect SHALL equal mem_write; both SHALL be 0 outside write cycles.
REQ-030 The word address SHALL increment by 1 after each write and wrap modulo 2^ADDR_W (8191 -> 0).
REQ-031 On acceptance of the last byte, the block SHALL enter FLUSH, during which the final write is driven, then DONE, with busy=0 and done=1 in cycle t+2.
REQ-032 busy SHALL be 1 in LOAD and FLUSH and 0 otherwise.
REQ-033 mem_clken SHALL be constantly 1.
REQ-034 sink_valid with sink_ready=0 SHALL not be consumed and SHALL not affect any state.

Reset
REQ-035 While reset=1 at a clock edge, the next state SHALL be IDLE, and sink_ready, mem_write, mem_chipselect, mem_byteenable, mem_writedata, mem_address, busy, done and checksum SHALL all be 0.
REQ-036 A reset during LOAD or FLUSH SHALL abort the load with no further write; a pending partial word SHALL be discarded.
REQ-037 reset SHALL take priority over start in the same cycle.

Configuration
REQ-038 With ONCHIP_LOADER_CHECKSUM_EN defined, checksum SHALL accumulate each accepted byte, zero-extended, modulo 2^16, and SHALL hold its value in DONE.
REQ-039 Without ONCHIP_LOADER_CHECKSUM_EN, checksum SHALL be tied to 16'h0000 and no accumulator SHALL be instantiated.

Verification
REQ-040 Full-word load: base=0x0010, length=8, bytes 01..08 with valid held high -> two writes: addr 0x0010 data 0x04030201 be 1111, then addr 0x0011 data 0x08070605 be 1111; done one cycle after the second write; checksum 0x0024 with the macro.
REQ-041 Partial tail: base=0x0100, length=6, bytes AA BB CC DD EE FF -> writes 0xDDCCBBAA/1111 at 0x0100, then 0x0000FFEE/0011 at 0x0101.
REQ-042 Wrap and gaps: base=0x1FFF, length=8, sink_valid toggled 1/0 -> writes to 0x1FFF then 0x0000; no write during gap cycles.
REQ-043 Zero length: start with length=0 -> done=1 next cycle, busy never 1, mem_write never 1.
REQ-044 Reset mid-load: assert reset after 5 of 8 bytes -> no further mem_write; all outputs 0 the cycle after; a subsequent start runs normally.
REQ-045 Ignored start: pulse start with a new base_addr during LOAD -> the original address sequence is unchanged and only one done occurs.
